seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the 7-seg display interface. Snoops the scanned anode/segment bus
//  (active-low, [7:0]=DP,g,f,e,d,c,b,a) and decodes each stable digit back to its hex nibble.
//  Reassembles one full scan into a 4*DIGITS-bit word. Used for board loopback self-test
//  of the CPU's register/PC display path.
// PARAMETERS
//  DIGITS         8   number of multiplexed digits (anode lines)
//  STABLE_CYCLES  4   consecutive unchanged cycles (an_i and seg_i) required before a digit is sampled
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         synchronous, active-high reset
//  an_i          in   DIGITS    anode select, active-low, one-hot when a digit is lit
//  seg_i         in   8         segment code, active-low, [7]=DP
//  word_o        out  4*DIGITS  decoded word; digit k -> word_o[4k+3:4k]
//  dp_o          out  DIGITS    decoded DP per digit (1 = DP lit)
//  frame_done_o  out  1         1-cycle pulse, asserted in the same cycle word_o/dp_o/err_o update
//  err_o         out  1         last completed frame contained >=1 undecodable code
// BEHAVIOUR
//  - Reset: word_o=0, dp_o=0, frame_done_o=0, err_o=0. Stability counter, captured mask, shadow
//    word, shadow err and FSM all cleared. Partial frame discarded; reset mid-scan restarts capture.
//  - Valid anode: exactly one bit of an_i low. All-high (blank) or multiple-low: counter held at 0,
//    nothing sampled, FSM -> WAIT.
//  - Per-digit FSM: WAIT -> (counter reaches STABLE_CYCLES-1 with an_i,seg_i unchanged, valid anode)
//    -> CAPTURED (sample once) -> stays until an_i or seg_i changes -> WAIT. Any input change resets
//    the counter to 0. Exactly one capture per stable dwell.
//  - Decode seg_i[6:0]: 40->0 79->1 24->2 30->3 19->4 12->5 02->6 58->7 00->8 10->9 08->A
//    03->b 46->C 21->d 06->E 0E->F. Any other pattern: nibble 0, shadow err set.
//    dp = ~seg_i[7], independent of the [6:0] decode.
//  - Capture writes digit k of the shadow word and dp and sets mask bit k. Re-capture of a digit
//    already in the mask overwrites its shadow value; no double count.
//  - Frame complete: when the mask becomes all-ones, the next cycle copies shadow -> word_o/dp_o,
//    shadow err -> err_o, pulses frame_done_o, and clears mask and shadow err.
//    A capture in that copy cycle belongs to the new frame.
//  - Latency: final-digit capture at cycle N -> outputs update and pulse at N+1.
//    Minimum dwell per digit = STABLE_CYCLES cycles.
//  - Outputs hold between frames; an incomplete scan never updates word_o.
// CONFIGURATION
//  SEG_ERR_CNT_EN defined: extra port err_cnt_o out 16, counts undecodable captures, saturates at
//    16'hFFFF, cleared only by rst.
//  SEG_ERR_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package seg_pkg: 16 segment-pattern constants (shared with the hex-to-seg encoder),
//    SEG_BLANK=8'hFF, FSM state encoding {WAIT, CAPTURED}.
//  - Sub-module seg_to_hex: combinational seg[6:0] -> {valid, nibble[3:0]}, instantiated once.
//  - Top holds the FSM, stability counter, one-hot check, mask, shadow registers and output
//    registers.
// TESTING
//  1. Scan 1..8 digits of 32'h1234ABCD, 4 cycles each -> one frame_done_o pulse,
//     word_o=32'h1234ABCD, err_o=0.
//  2. Digit 3 with seg_i=8'hFF, others valid -> word_o nibble 3 = 0, err_o=1.
//     With SEG_ERR_CNT_EN: err_cnt_o=1.
//  3. Dwell of 3 cycles per digit (STABLE_CYCLES=4) -> no capture, no frame_done_o,
//     word_o unchanged.
//  4. an_i=8'hFF, then an_i=8'b1111_1100 for 10 cycles -> no capture.
//     A following valid scan completes normally.
//  5. rst after 5 of 8 digits, then full scan of 32'hDEADBEEF -> single pulse,
//     word_o=32'hDEADBEEF, no leftover digits.
//  6. Digit 0 with seg_i=8'h40 (DP lit), then full scan -> dp_o[0]=1, word_o[3:0]=0;
//     digit 0 rescanned with 8'h79 before frame end -> word_o[3:0]=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment
// patterns for the 16 hex glyphs ([6:0] = g,f,e,d,c,b,a), the blank code and
// the per-digit capture state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h58;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments and the DP dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    WAIT     = 1'b0,
    CAPTURED = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational inverse of the hex-to-7-seg encoder: maps an active-low
// segment pattern back to its nibble and flags patterns that are not a glyph.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup; unknown patterns decode to 0 with valid low.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed, active-low 7-segment anode/segment bus, samples each
// digit once it has been stable for STABLE_CYCLES cycles, and publishes a
// complete scan as one 4*DIGITS-bit word plus per-digit DP bits.
// Optional build macro SEG_ERR_CNT_EN adds err_cnt_o, a saturating count of
// undecodable captures.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [7:0]            seg_i,
  output logic [4*DIGITS-1:0]   word_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic                  frame_done_o,
  output logic                  err_o
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt_o
`endif
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  scan_state_t       state, state_next;
  logic [DIGITS-1:0] an_prev;
  logic [7:0]        seg_prev;
  logic [CNT_W-1:0]  cnt, cnt_cur;
  logic [DIGITS-1:0] an_lit;
  logic              one_hot;
  logic              changed;
  logic              stable_hit;
  logic              capture;
  logic [IDX_W-1:0]  digit;
  logic              code_valid;
  logic [3:0]        code_nibble;

  logic [DIGITS-1:0]   mask, mask_next;
  logic [4*DIGITS-1:0] shadow_word;
  logic [DIGITS-1:0]   shadow_dp;
  logic                shadow_err, shadow_err_next;
  logic                frame_full;

  seg_to_hex u_seg_to_hex (
    .seg    (seg_i[6:0]),
    .valid  (code_valid),
    .nibble (code_nibble)
  );

  assign an_lit     = ~an_i;
  assign one_hot    = (an_lit != '0) && ((an_lit & (an_lit - DIGITS'(1))) == '0);
  assign changed    = (an_i != an_prev) || (seg_i != seg_prev);
  assign stable_hit = one_hot && (cnt_cur == CNT_MAX);
  assign frame_full = &mask;

  // Position of the lit anode; only meaningful when one_hot is set.
  always_comb begin
    digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (an_lit[k]) digit = IDX_W'(k);
    end
  end

  // Dwell length of the current bus value, saturating at the sample point.
  always_comb begin
    if (changed || !one_hot) cnt_cur = '0;
    else if (cnt == CNT_MAX) cnt_cur = cnt;
    else                     cnt_cur = cnt + 1'b1;
  end

  // Previous bus value and stability counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      an_prev  <= '1;
      seg_prev <= SEG_BLANK;
      cnt      <= '0;
    end else begin
      an_prev  <= an_i;
      seg_prev <= seg_i;
      cnt      <= cnt_cur;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_next;
  end

  // FSM next state: one capture per stable dwell, re-armed by any bus change.
  always_comb begin
    state_next = state;
    case (state)
      WAIT:     if (capture) state_next = CAPTURED;
      CAPTURED: if (changed || !one_hot) state_next = capture ? CAPTURED : WAIT;
      default:  state_next = WAIT;
    endcase
  end

  // FSM output: sample strobe. A change leaving CAPTURED may capture at once
  // only when a single stable cycle suffices.
  always_comb begin
    capture = stable_hit && ((state == WAIT) || changed);
  end

  // Mask and shadow error bookkeeping; a capture in the copy cycle seeds the
  // next frame instead of being lost.
  always_comb begin
    mask_next       = frame_full ? '0 : mask;
    shadow_err_next = frame_full ? 1'b0 : shadow_err;
    if (capture) begin
      mask_next       = mask_next | an_lit;
      shadow_err_next = shadow_err_next | ~code_valid;
    end
  end

  // Shadow frame capture and publication to the output registers.
  always_ff @(posedge clk) begin
    // NOTE: the shadow word is explicitly cleared on reset; it is a register
    // bank, not a RAM, so the reset costs nothing and keeps state defined.
    if (rst) begin
      mask         <= '0;
      shadow_word  <= '0;
      shadow_dp    <= '0;
      shadow_err   <= 1'b0;
      word_o       <= '0;
      dp_o         <= '0;
      err_o        <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      mask         <= mask_next;
      shadow_err   <= shadow_err_next;
      frame_done_o <= frame_full;
      if (frame_full) begin
        word_o <= shadow_word;
        dp_o   <= shadow_dp;
        err_o  <= shadow_err;
      end
      if (capture) begin
        shadow_word[4*digit +: 4] <= code_nibble;
        shadow_dp[digit]          <= ~seg_i[7];
      end
    end
  end

`ifdef SEG_ERR_CNT_EN
  logic [15:0] err_cnt;

  // Saturating count of undecodable captures, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                               err_cnt <= '0;
    else if (capture && !code_valid && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end

  assign err_cnt_o = err_cnt;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each bus dwell is fed to a
// frame-level reference model that predicts completed frames; a monitor pops
// a prediction on every frame_done_o pulse and compares.
module tb_seg_scan_decoder;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;
  logic [4*DIGITS-1:0] word;
  logic [DIGITS-1:0]   dp;
  logic                frame_done;
  logic                err;
`ifdef SEG_ERR_CNT_EN
  logic [15:0]         err_cnt;
`endif

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .an_i         (an),
    .seg_i        (seg),
    .word_o       (word),
    .dp_o         (dp),
    .frame_done_o (frame_done),
    .err_o        (err)
`ifdef SEG_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  dp;
    logic        err;
    int unsigned ecnt;
  } frame_t;

  frame_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Hex glyph table, active-low g..a.
  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  logic [3:0]  m_nib [DIGITS];
  logic [7:0]  m_dp;
  logic [7:0]  m_have;
  logic        m_err;
  int unsigned m_ecnt;
  logic [31:0] out_word;
  logic [7:0]  out_dp;
  logic        out_err;
  logic [7:0]  last_an;
  logic [7:0]  last_seg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_decode(input logic [6:0] s, output logic [3:0] n);
    n = 4'h0;
    for (int h = 0; h < 16; h++) begin
      if (enc[h] == s) begin
        n = 4'(h);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // A dwell captures iff exactly one anode is lit and it lasts STABLE cycles.
  task automatic model_dwell(input logic [7:0] a, input logic [7:0] s, input int len);
    int k;
    logic [3:0] n;
    bit ok;
    frame_t f;
    if ($countones(~a) != 1 || len < STABLE) return;
    k = 0;
    for (int i = 0; i < DIGITS; i++) if (!a[i]) k = i;
    ok = model_decode(s[6:0], n);
    m_nib[k] = ok ? n : 4'h0;
    m_dp[k]  = ~s[7];
    m_have[k] = 1'b1;
    if (!ok) begin
      m_err = 1'b1;
      if (m_ecnt < 65535) m_ecnt++;
    end
    if (&m_have) begin
      for (int i = 0; i < DIGITS; i++) f.word[4*i +: 4] = m_nib[i];
      f.dp   = m_dp;
      f.err  = m_err;
      f.ecnt = m_ecnt;
      exp_q.push_back(f);
      out_word = f.word;
      out_dp   = f.dp;
      out_err  = f.err;
      m_have   = '0;
      m_err    = 1'b0;
    end
  endtask

  task automatic drive_raw(input logic [7:0] a, input logic [7:0] s, input int len);
    model_dwell(a, s, len);
    an  = a;
    seg = s;
    last_an  = a;
    last_seg = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // A repeated lit value would merge with the previous dwell, so separate it.
  task automatic dwell(input logic [7:0] a, input logic [7:0] s, input int len);
    if ($countones(~a) == 1 && a == last_an && s == last_seg) drive_raw(8'hFF, 8'hFF, 1);
    drive_raw(a, s, len);
  endtask

  task automatic scan_digit(input int k, input logic [3:0] n, input int len);
    logic [7:0] a;
    a = ~(8'(1) << k);
    dwell(a, {1'b1, enc[n]}, len);
  endtask

  task automatic scan_word(input logic [31:0] w, input int len);
    for (int k = 0; k < DIGITS; k++) scan_digit(k, w[4*k +: 4], len);
  endtask

  task automatic settle_check(input string tag);
    drive_raw(8'hFF, 8'hFF, 3);
    check({tag, "_word"}, word, out_word);
    check({tag, "_dp"}, dp, out_dp);
    check({tag, "_err"}, err, out_err);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    drive_raw(8'hFF, 8'hFF, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_have = '0; m_err = 1'b0; m_ecnt = 0; m_dp = '0;
    out_word = '0; out_dp = '0; out_err = 1'b0;
    last_an = 8'hFF; last_seg = 8'hFF;
    check("rst_word", word, 32'h0);
    check("rst_dp", dp, 8'h0);
    check("rst_err", err, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
`ifdef SEG_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 16'h0);
`endif
  endtask

  // Monitor: every frame_done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame_done: got pulse with word %0h expected no pulse", word);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        check("frame_word", word, f.word);
        check("frame_dp", dp, f.dp);
        check("frame_err", err, f.err);
`ifdef SEG_ERR_CNT_EN
        check("frame_err_cnt", err_cnt, 64'(f.ecnt));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, len, r;
    logic [7:0] a, s;
    rst = 1'b1; an = 8'hFF; seg = 8'hFF;
    last_an = 8'hFF; last_seg = 8'hFF;
    m_have = '0; m_err = 1'b0; m_ecnt = 0; m_dp = '0;
    out_word = '0; out_dp = '0; out_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // 1: clean scan at minimum dwell.
    scan_word(32'h1234ABCD, STABLE);
    settle_check("t1");

    // 2: blank code on digit 3 decodes to 0 and flags the frame.
    for (int d = 0; d < DIGITS; d++) begin
      if (d == 3) dwell(~8'h08, 8'hFF, STABLE);
      else        scan_digit(d, 4'(32'h1234ABCD >> (4*d)), STABLE);
    end
    settle_check("t2");

    // 3: one cycle too short everywhere, nothing captured.
    scan_word(32'h55555555, STABLE - 1);
    settle_check("t3");

    // 4: blank, then two anodes lit, then a normal scan.
    drive_raw(8'hFF, 8'hFF, 3);
    drive_raw(8'hFC, {1'b1, enc[8]}, 10);
    settle_check("t4a");
    scan_word(32'h0F1E2D3C, STABLE + 1);
    settle_check("t4b");

    // 5: reset mid-scan discards the partial frame.
    for (int d = 0; d < 5; d++) scan_digit(d, 4'h7, STABLE);
    do_reset();
    scan_word(32'hDEADBEEF, STABLE);
    settle_check("t5");

    // 6: DP on digit 0, then a rescan of digit 0 before the frame ends.
    dwell(8'hFE, 8'h40, STABLE);
    for (int d = 1; d < DIGITS; d++) scan_digit(d, 4'(d), STABLE);
    settle_check("t6a");
    dwell(8'hFE, 8'h40, STABLE);
    dwell(8'hFE, 8'h79, STABLE);
    for (int d = 1; d < DIGITS; d++) scan_digit(d, 4'(15 - d), STABLE);
    settle_check("t6b");

    // Random traffic: mixed dwell lengths, bad codes, invalid anodes, resets.
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 99));
      len = int'($urandom_range(STABLE - 1, STABLE + 3));
      k   = int'($urandom_range(0, DIGITS - 1));
      a   = ~(8'(1) << k);
      s   = {1'($urandom_range(0, 1)), enc[$urandom_range(0, 15)]};
      if (r < 8)        s = 8'($urandom);
      else if (r < 12)  a = 8'hFF;
      else if (r < 16)  a = a & ~(8'(1) << ((k + 1) % DIGITS));
      if (r == 99) do_reset();
      else         dwell(a, s, len);
    end
    settle_check("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
